heart_beat_multi: RTL and testbench
===================================

Name: heart_beat_multi

Overview:
Multi-channel successor to the single-LED heartbeat generator; drives CHANNELS status LEDs from one clock (e.g. pcie_axi_clk).
A shared prescaler produces a slow tick. Each channel independently runs OFF, ON, BLINK (programmable half-period) or CODE (N blinks then a long gap) mode.
Used for link/error/activity status LEDs in the PCIe top levels.

Parameters:
CLK_VALUE, 100000000, input clock frequency in Hz
TICK_HZ, 1000, prescaler tick rate in Hz; DIV = CLK_VALUE/TICK_HZ, elaboration error if DIV < 2
CHANNELS, 4, number of LED channels (1..32)
PERIOD_W, 10, width of per-channel half-period field in ticks
CODE_W, 4, width of per-channel blink-count field

Ports:
i_clk  input  1  system clock
i_arst_n  input  1  asynchronous active-low reset
i_mode  input  2*CHANNELS  per-channel mode, ch k at [2k+1:2k]: 0 OFF, 1 ON, 2 BLINK, 3 CODE
i_half_period  input  PERIOD_W*CHANNELS  per-channel on/off half-period in ticks
i_code_cnt  input  CODE_W*CHANNELS  per-channel blink count for CODE mode
i_sync  input  1  synchronous restart of prescaler and all channels
o_tick  output  1  one-cycle prescaler tick pulse
o_led  output  CHANNELS  registered LED drive, 1 = lit

Behaviour:
- Reset (async assert, sync-released internally by a 2-FF synchroniser): o_led = 0, o_tick = 0, prescaler = 0, all channel FSMs in S_IDLE, mode_q = OFF.
- Reset asserted mid-sequence: outputs clear immediately, with no clock needed.
- Prescaler: counts 0..DIV-1 and wraps. o_tick = 1 for exactly the cycle after count reaches DIV-1, so the tick period is DIV cycles.
- Effective half-period hp = max(i_half_period, 1). Effective count cc = i_code_cnt; cc = 0 means the channel stays dark.
- Channel (re)start event: reset release, i_sync, or i_mode != mode_q (mode_q is registered every cycle).
- On a start event the channel, in the next cycle:
  - clears tick_cnt and pulse_cnt;
  - latches hp and cc into shadow registers;
  - OFF: led = 0, state S_IDLE.
  - ON: led = 1, state S_IDLE.
  - BLINK, or CODE with cc > 0: led = 1, state S_ON.
  - CODE with cc = 0: led = 0, state S_IDLE.
- Counting happens only on o_tick cycles.
- S_ON: when tick_cnt == hp-1:
  - tick_cnt = 0, led = 0, pulse_cnt++.
  - CODE with pulse_cnt+1 == cc goes to S_GAP; otherwise S_OFF.
- S_OFF: when tick_cnt == hp-1:
  - tick_cnt = 0, led = 1, go to S_ON.
  - BLINK re-latches hp here.
- S_GAP: length 4*hp ticks (counter width PERIOD_W+2). At its end:
  - re-latch hp and cc, pulse_cnt = 0;
  - go to S_ON with led = 1 if cc > 0, else S_IDLE with led = 0.
- CODE in S_IDLE with cc = 0 re-samples i_code_cnt on every tick and starts S_ON when it becomes nonzero.
- Changes to i_half_period or i_code_cnt without a mode change take effect only at the re-latch points, so there are no truncated pulses.
- i_sync: prescaler cleared in the same cycle, all channels restart as above. i_sync has priority over a simultaneous tick or mode change.
- Latency: o_led changes one cycle after the o_tick cycle that completes a phase.
- The first phase after a start is hp ticks counted from the next tick, i.e. (hp-1)*DIV+1 .. hp*DIV cycles. After i_sync it is exactly hp*DIV cycles.

Decomposition:
- Package heart_beat_pkg holds:
  - mode_t enum (MODE_OFF, MODE_ON, MODE_BLINK, MODE_CODE);
  - state_t enum (S_IDLE, S_ON, S_OFF, S_GAP);
  - GAP_MULT = 4;
  - function calc_div(clk, hz).
- Sub-module heart_beat_channel contains one channel's FSM, counters and shadow registers. It takes the tick, sync, mode, hp and cc and drives one led bit. It is generate-instantiated CHANNELS times; the prescaler and sync logic stay in the top.

Test Plan:
- All tests use CLK_VALUE=100, TICK_HZ=10 (DIV=10).
- Prescaler: run 1000 cycles after reset -> o_tick high exactly 1 cycle every 10, first pulse 10 cycles after i_sync.
- BLINK: ch0 mode=2, hp=3, pulse i_sync -> o_led[0] high 30 cycles, low 30, repeating, period 60.
- CODE: ch1 mode=3, hp=2, cc=3, i_sync -> on20 off20 on20 off20 on20 off80, period 180. Changing cc to 1 mid-sequence alters only the next period.
- Degenerate values: ch2 CODE cc=0 -> o_led[2] stays 0; then cc=2 -> blinking starts one cycle after the next tick. hp=0 behaves as hp=1 (10 on/10 off).
- Mode change and alignment: ch3 switches BLINK->ON mid-phase -> o_led[3]=1 next cycle and stays 1. After i_sync, two BLINK channels with equal hp toggle on identical cycles.
- Async reset: drop i_arst_n between clock edges during CODE -> o_led and o_tick = 0 with no clock edge. Release -> all channels restart and ON-mode channels light within 3 cycles.

Source files
------------

// File: rtl/heart_beat_pkg.sv
// Shared types and helpers for the multi-channel heartbeat LED generator.
package heart_beat_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CODE  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int GAP_MULT = 4;

    function automatic int calc_div(input longint clk_hz, input longint tick_hz);
        return int'(clk_hz / tick_hz);
    endfunction

endpackage

// File: rtl/heart_beat_channel.sv
// One LED channel: mode FSM, tick/pulse counters and the hp/cc shadow registers.
module heart_beat_channel
    import heart_beat_pkg::*;
#(
    parameter int PERIOD_W = 10,
    parameter int CODE_W   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tick,
    input  logic                i_restart,
    input  logic [1:0]          i_mode,
    input  logic [PERIOD_W-1:0] i_half_period,
    input  logic [CODE_W-1:0]   i_code_cnt,
    output logic                o_led
);
    localparam int CNT_W = PERIOD_W + 2;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d, mode_in;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [CODE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [PERIOD_W-1:0] hp_q, hp_d;
    logic [CODE_W-1:0]   cc_q, cc_d;
    logic                led_q, led_d;

    logic [PERIOD_W-1:0] hp_eff;
    logic [CNT_W-1:0]    hp_ext;
    logic [CNT_W-1:0]    phase_last;
    logic [CNT_W-1:0]    gap_last;
    logic                restart;

    assign mode_in    = mode_t'(i_mode);
    assign hp_eff     = (i_half_period == '0) ? PERIOD_W'(1) : i_half_period;
    assign hp_ext     = CNT_W'(hp_q);
    assign phase_last = hp_ext - CNT_W'(1);
    assign gap_last   = hp_ext * CNT_W'(GAP_MULT) - CNT_W'(1);
    assign restart    = i_restart || (mode_in != mode_q);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_in;
        tick_cnt_d  = tick_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        hp_d        = hp_q;
        cc_d        = cc_q;
        led_d       = led_q;

        if (restart) begin
            tick_cnt_d  = '0;
            pulse_cnt_d = '0;
            hp_d        = hp_eff;
            cc_d        = i_code_cnt;
            case (mode_in)
                MODE_OFF: begin
                    led_d   = 1'b0;
                    state_d = S_IDLE;
                end
                MODE_ON: begin
                    led_d   = 1'b1;
                    state_d = S_IDLE;
                end
                MODE_BLINK: begin
                    led_d   = 1'b1;
                    state_d = S_ON;
                end
                default: begin
                    led_d   = (i_code_cnt != '0);
                    state_d = (i_code_cnt != '0) ? S_ON : S_IDLE;
                end
            endcase
        end else if (i_tick) begin
            case (state_q)
                S_IDLE: begin
                    // A dark CODE channel keeps watching for a nonzero count.
                    if (mode_q == MODE_CODE && cc_q == '0 && i_code_cnt != '0) begin
                        hp_d        = hp_eff;
                        cc_d        = i_code_cnt;
                        tick_cnt_d  = '0;
                        pulse_cnt_d = '0;
                        led_d       = 1'b1;
                        state_d     = S_ON;
                    end
                end
                S_ON: begin
                    if (tick_cnt_q == phase_last) begin
                        tick_cnt_d  = '0;
                        led_d       = 1'b0;
                        pulse_cnt_d = pulse_cnt_q + CODE_W'(1);
                        if (mode_q == MODE_CODE && (pulse_cnt_q + CODE_W'(1)) == cc_q) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_OFF;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (tick_cnt_q == phase_last) begin
                        tick_cnt_d = '0;
                        led_d      = 1'b1;
                        state_d    = S_ON;
                        if (mode_q == MODE_BLINK) begin
                            hp_d = hp_eff;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (tick_cnt_q == gap_last) begin
                        tick_cnt_d  = '0;
                        pulse_cnt_d = '0;
                        hp_d        = hp_eff;
                        cc_d        = i_code_cnt;
                        led_d       = (i_code_cnt != '0);
                        state_d     = (i_code_cnt != '0) ? S_ON : S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_OFF;
            tick_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            hp_q        <= PERIOD_W'(1);
            cc_q        <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tick_cnt_q  <= tick_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            hp_q        <= hp_d;
            cc_q        <= cc_d;
            led_q       <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/heart_beat_multi.sv
// Multi-channel heartbeat LED generator: reset synchroniser, shared prescaler
// and one heart_beat_channel per LED.
module heart_beat_multi
    import heart_beat_pkg::*;
#(
    parameter int CLK_VALUE = 100000000,
    parameter int TICK_HZ   = 1000,
    parameter int CHANNELS  = 4,
    parameter int PERIOD_W  = 10,
    parameter int CODE_W    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic [2*CHANNELS-1:0]        i_mode,
    input  logic [PERIOD_W*CHANNELS-1:0] i_half_period,
    input  logic [CODE_W*CHANNELS-1:0]   i_code_cnt,
    input  logic                         i_sync,
    output logic                         o_tick,
    output logic [CHANNELS-1:0]          o_led
);
    localparam int DIV   = calc_div(CLK_VALUE, TICK_HZ);
    localparam int PRE_W = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("heart_beat_multi: CLK_VALUE/TICK_HZ must be at least 2");
    end
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_ch_check
        $error("heart_beat_multi: CHANNELS must be in 1..32");
    end

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_n;
    logic             start_q, start_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q, tick_d;

    // Reset asserts asynchronously but only releases on a clock edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // The i_sync cycle itself is prescaler phase 0, so the first tick lands DIV cycles later.
    always_comb begin
        start_d   = 1'b0;
        tick_d    = (pre_cnt_q == PRE_W'(DIV - 1));
        pre_cnt_d = (pre_cnt_q == PRE_W'(DIV - 1)) ? '0 : pre_cnt_q + PRE_W'(1);
        if (i_sync) begin
            pre_cnt_d = PRE_W'(1);
            tick_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            start_q   <= start_d;
        end
    end

    assign o_tick = tick_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        heart_beat_channel #(
            .PERIOD_W (PERIOD_W),
            .CODE_W   (CODE_W)
        ) u_channel (
            .i_clk         (i_clk),
            .i_rst_n       (rst_n),
            .i_tick        (tick_q),
            .i_restart     (i_sync || start_q),
            .i_mode        (i_mode[2*g +: 2]),
            .i_half_period (i_half_period[PERIOD_W*g +: PERIOD_W]),
            .i_code_cnt    (i_code_cnt[CODE_W*g +: CODE_W]),
            .o_led         (o_led[g])
        );
    end

endmodule

// File: tb/tb_heart_beat_multi.sv
// Self-checking bench for heart_beat_multi (DIV = 10): expected LED/tick
// waveforms are queued per scenario and drained against the DUT cycle by cycle.
module tb_heart_beat_multi;

    localparam int CH = 4;
    localparam int PW = 10;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [2*CH-1:0]  mode;
    logic [PW*CH-1:0] hp;
    logic [CW*CH-1:0] cc;
    logic             sync;
    logic             tick;
    logic [CH-1:0]    led;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    heart_beat_multi #(
        .CLK_VALUE (100),
        .TICK_HZ   (10),
        .CHANNELS  (CH),
        .PERIOD_W  (PW),
        .CODE_W    (CW)
    ) dut (
        .i_clk         (clk),
        .i_arst_n      (arst_n),
        .i_mode        (mode),
        .i_half_period (hp),
        .i_code_cnt    (cc),
        .i_sync        (sync),
        .o_tick        (tick),
        .o_led         (led)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] m, input logic [PW-1:0] p, input logic [CW-1:0] c);
        mode[2*ch +: 2] = m;
        hp[PW*ch +: PW] = p;
        cc[CW*ch +: CW] = c;
    endtask

    task automatic push_run(input logic v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    // Outputs must be dark during and just after reset with every channel OFF.
    task automatic test_reset();
        arst_n = 1'b0;
        mode   = '0;
        hp     = '0;
        cc     = '0;
        sync   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_led: got %b, want 0000", led);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tick: got %b, want 0", tick);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (4) step();
        checks++;
        if (led !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_release_led: got %b, want 0000", led);
        end
    endtask

    // One tick every 10 cycles, the first 10 cycles after the sync cycle.
    task automatic test_prescaler();
        logic exp;
        int   highs;
        highs = 0;
        do_sync();
        for (int k = 0; k < 1000; k++) exp_q.push_back((k % 10) == 9);
        for (int k = 0; k < 1000; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("[TB] FAIL prescaler_tick k=%0d: got %b, want %b", k, tick, exp);
            end
            if (tick === 1'b1) highs++;
            step();
        end
        checks++;
        if (highs != 100) begin
            errors++;
            $display("[TB] FAIL prescaler_count: got %0d, want 100", highs);
        end
    endtask

    task automatic test_blink();
        logic exp;
        set_ch(0, 2'd2, 10'd3, 4'd0);
        do_sync();
        repeat (3) begin
            push_run(1'b1, 30);
            push_run(1'b0, 30);
        end
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp = exp_q.pop_front();
            checks++;
            if (led[0] !== exp) begin
                errors++;
                $display("[TB] FAIL blink_led0 n=%0d: got %b, want %b", n, led[0], exp);
            end
            step();
        end
    endtask

    // Three blinks then a 4*hp gap; a count change only shows up after the next gap.
    task automatic test_code();
        logic exp;
        set_ch(1, 2'd3, 10'd2, 4'd3);
        do_sync();
        repeat (2) begin
            push_run(1'b1, 20); push_run(1'b0, 20);
            push_run(1'b1, 20); push_run(1'b0, 20);
            push_run(1'b1, 20); push_run(1'b0, 80);
        end
        push_run(1'b1, 20); push_run(1'b0, 80);
        push_run(1'b1, 20);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp = exp_q.pop_front();
            checks++;
            if (led[1] !== exp) begin
                errors++;
                $display("[TB] FAIL code_led1 n=%0d: got %b, want %b", n, led[1], exp);
            end
            if (n == 230) cc[CW*1 +: CW] = 4'd1;
            step();
        end
    endtask

    task automatic test_degenerate();
        logic exp;
        int   waited;
        set_ch(0, 2'd0, 10'd0, 4'd0);
        set_ch(2, 2'd3, 10'd1, 4'd0);
        step();
        push_run(1'b0, 30);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp = exp_q.pop_front();
            checks++;
            if (led[2] !== exp) begin
                errors++;
                $display("[TB] FAIL cc0_dark n=%0d: got %b, want %b", n, led[2], exp);
            end
            step();
        end
        cc[CW*2 +: CW] = 4'd2;
        waited = 0;
        while (tick !== 1'b1 && waited < 20) begin
            checks++;
            if (led[2] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cc_wait_dark: got %b, want 0", led[2]);
            end
            step();
            waited++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cc_tick_timeout: got tick %b after %0d cycles, want 1", tick, waited);
        end else begin
            step();
            push_run(1'b1, 10); push_run(1'b0, 10);
            push_run(1'b1, 10); push_run(1'b0, 40);
            push_run(1'b1, 10);
            for (int n = 0; exp_q.size() > 0; n++) begin
                exp = exp_q.pop_front();
                checks++;
                if (led[2] !== exp) begin
                    errors++;
                    $display("[TB] FAIL cc2_start n=%0d: got %b, want %b", n, led[2], exp);
                end
                step();
            end
        end
        set_ch(2, 2'd2, 10'd0, 4'd0);
        do_sync();
        repeat (3) begin
            push_run(1'b1, 10);
            push_run(1'b0, 10);
        end
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp = exp_q.pop_front();
            checks++;
            if (led[2] !== exp) begin
                errors++;
                $display("[TB] FAIL hp0_blink n=%0d: got %b, want %b", n, led[2], exp);
            end
            step();
        end
    endtask

    // BLINK->ON mid off-phase, then two equal-hp BLINK channels after a sync.
    task automatic test_mode_change();
        logic exp;
        set_ch(2, 2'd0, 10'd0, 4'd0);
        set_ch(3, 2'd2, 10'd3, 4'd0);
        do_sync();
        push_run(1'b1, 30);
        push_run(1'b0, 11);
        push_run(1'b1, 60);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp = exp_q.pop_front();
            checks++;
            if (led[3] !== exp) begin
                errors++;
                $display("[TB] FAIL mode_on_led3 n=%0d: got %b, want %b", n, led[3], exp);
            end
            if (n == 40) mode[2*3 +: 2] = 2'd1;
            step();
        end
        set_ch(0, 2'd2, 10'd4, 4'd0);
        set_ch(3, 2'd2, 10'd4, 4'd0);
        do_sync();
        repeat (2) begin
            push_run(1'b1, 40);
            push_run(1'b0, 40);
        end
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp = exp_q.pop_front();
            checks++;
            if (led[0] !== exp) begin
                errors++;
                $display("[TB] FAIL align_led0 n=%0d: got %b, want %b", n, led[0], exp);
            end
            checks++;
            if (led[3] !== exp) begin
                errors++;
                $display("[TB] FAIL align_led3 n=%0d: got %b, want %b", n, led[3], exp);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        set_ch(0, 2'd0, 10'd0, 4'd0);
        set_ch(1, 2'd3, 10'd2, 4'd3);
        set_ch(2, 2'd0, 10'd0, 4'd0);
        set_ch(3, 2'd1, 10'd0, 4'd0);
        do_sync();
        repeat (9) step();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arst_pre_tick: got %b, want 1", tick);
        end
        checks++;
        if (led !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL arst_pre_led: got %b, want 1010", led);
        end
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arst_tick_clear: got %b, want 0", tick);
        end
        checks++;
        if (led !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL arst_led_clear: got %b, want 0000", led);
        end
        repeat (2) step();
        checks++;
        if (led !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL arst_led_held: got %b, want 0000", led);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL arst_release_led: got %b, want 1010", led);
        end
    endtask

    initial begin
        $display("[TB] heart_beat_multi bench start");
        test_reset();
        test_prescaler();
        test_blink();
        test_code();
        test_degenerate();
        test_mode_change();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
